// File: rtl/dec3to8_pulse.sv
// Registered 3-to-8 decoder: each accepted code drives a one-hot pulse, then an all-zero gap.
// Optional one-entry skid buffer enabled by defining DEC3TO8_PULSE_SKID_EN.
module dec3to8_pulse #(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_code,
   output logic [7:0] q,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned CODE_W = 3;
   localparam int unsigned Q_W    = 8;

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [Q_W-1:0]     q_n;
   logic               busy_n;
   logic               done_n;
   logic               xfer_c;
   logic [Q_W-1:0]     onehot_in_c;

`ifdef DEC3TO8_PULSE_SKID_EN
   logic               skid_full, skid_full_n;
   logic [CODE_W-1:0]  skid_code, skid_code_n;
   logic [Q_W-1:0]     onehot_skid_c;

   assign in_ready      = en && !skid_full;
   assign onehot_skid_c = Q_W'(1) << skid_code;
`else
   assign in_ready      = en && (state == IDLE);
`endif

   assign xfer_c      = in_valid && in_ready;
   assign onehot_in_c = Q_W'(1) << in_code;

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef DEC3TO8_PULSE_SKID_EN
         skid_full <= 1'b0;
         skid_code <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         q     <= q_n;
         busy  <= busy_n;
         done  <= done_n;
`ifdef DEC3TO8_PULSE_SKID_EN
         skid_full <= skid_full_n;
         skid_code <= skid_code_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      q_n     = q;
      done_n  = 1'b0;
`ifdef DEC3TO8_PULSE_SKID_EN
      skid_full_n = skid_full;
      skid_code_n = skid_code;
`endif
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         q_n     = '0;
`ifdef DEC3TO8_PULSE_SKID_EN
         skid_full_n = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef DEC3TO8_PULSE_SKID_EN
               if (skid_full) begin
                  state_n     = ACTIVE;
                  q_n         = onehot_skid_c;
                  cnt_n       = CNT_W'(PULSE_LEN - 1);
                  skid_full_n = 1'b0;
               end else
`endif
               if (xfer_c) begin
                  state_n = ACTIVE;
                  q_n     = onehot_in_c;
                  cnt_n   = CNT_W'(PULSE_LEN - 1);
               end
            end
            ACTIVE: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else begin
                  done_n = 1'b1;
                  q_n    = '0;
                  if (GAP_LEN > 0) begin
                     state_n = GAP;
                     cnt_n   = CNT_W'(GAP_LEN - 1);
                  end else begin
                     state_n = IDLE;
                     cnt_n   = '0;
`ifdef DEC3TO8_PULSE_SKID_EN
                     if (skid_full) begin
                        state_n     = ACTIVE;
                        q_n         = onehot_skid_c;
                        cnt_n       = CNT_W'(PULSE_LEN - 1);
                        skid_full_n = 1'b0;
                     end
`endif
                  end
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else begin
                  state_n = IDLE;
`ifdef DEC3TO8_PULSE_SKID_EN
                  if (skid_full) begin
                     state_n     = ACTIVE;
                     q_n         = onehot_skid_c;
                     cnt_n       = CNT_W'(PULSE_LEN - 1);
                     skid_full_n = 1'b0;
                  end
`endif
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               q_n     = '0;
            end
         endcase
`ifdef DEC3TO8_PULSE_SKID_EN
         // A code arriving mid-pulse waits in the skid entry
         if (xfer_c && (state != IDLE)) begin
            skid_full_n = 1'b1;
            skid_code_n = in_code;
         end
`endif
      end
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_dec3to8_pulse.sv
// Self-checking bench for dec3to8_pulse: directed scenarios plus random traffic against a timeline model.
module tb_dec3to8_pulse;

   localparam int P = 4;
   localparam int G = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_code = 3'd0;
   logic [7:0] q;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   // Timeline model: a pulse started at cycle s shows q in s+1..s+P, done at s+P+1, busy through s+P+G
   int         n = 0;
   bit         m_act = 0;
   int         m_start = 0;
   bit [2:0]   m_code = 0;
   int         m_done = -1;
   int         m_done_prev = -1;
   bit         m_pend = 0;
   bit [2:0]   m_pcode = 0;

   dec3to8_pulse #(.PULSE_LEN(P), .GAP_LEN(G)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .q        (q),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   function automatic bit m_idle();
      return !m_act || (n - m_start > P + G);
   endfunction

   function automatic logic [7:0] exp_q();
      logic [7:0] v;
      int k;
      v = 8'h01;
      k = n - m_start;
      if (m_act && k >= 1 && k <= P) return v << m_code;
      return 8'h00;
   endfunction

   function automatic bit exp_busy();
      return m_act && (n - m_start <= P + G);
   endfunction

   function automatic bit exp_done();
      return (n == m_done) || (n == m_done_prev);
   endfunction

   function automatic bit exp_ready();
`ifdef DEC3TO8_PULSE_SKID_EN
      return en && !m_pend;
`else
      return en && m_idle();
`endif
   endfunction

   task automatic m_clear();
      m_act = 0;
      m_pend = 0;
      m_done = -1;
      m_done_prev = -1;
   endtask

   task automatic m_launch(input bit [2:0] c);
      m_act = 1;
      m_start = n;
      m_code = c;
      m_done_prev = m_done;
      m_done = n + P + 1;
   endtask

   // Advance the model across one rising edge using the inputs held before it
   task automatic model_step();
      bit xfer;
      bit idle;
      xfer = in_valid && exp_ready();
      idle = m_idle();
      if (!en) begin
         m_clear();
      end else begin
`ifdef DEC3TO8_PULSE_SKID_EN
         if (m_pend && (idle || (n - m_start == P + G))) begin
            m_launch(m_pcode);
            m_pend = 0;
         end else if (xfer) begin
            if (idle) m_launch(in_code);
            else begin
               m_pend = 1;
               m_pcode = in_code;
            end
         end
`else
         if (xfer) m_launch(in_code);
`endif
      end
      n++;
   endtask

   task automatic check_outputs();
      chk("q", 32'(q), 32'(exp_q()));
      chk("busy", 32'(busy), 32'(exp_busy()));
      chk("done", 32'(done), 32'(exp_done()));
      chk("onehot", 32'($countones(q) <= 1), 32'd1);
   endtask

   // One clock cycle starting at a falling edge: drive, check ready, clock, check outputs
   task automatic cycle(input bit e, input bit v, input bit [2:0] c);
      en = e;
      in_valid = v;
      in_code = c;
      #1;
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      m_clear();

      // Single pulse of code 5 followed by its gap
      cycle(1, 1, 3'd5);
      chk("code5_q", 32'(q), 32'h20);
      repeat (P + G + 2) cycle(1, 0, 3'd0);

      // Sweep every code
      for (int c = 0; c < 8; c++) begin
         cycle(1, 1, 3'(c));
         repeat (P + G) cycle(1, 0, 3'd0);
      end

      // Abort in the second pulse cycle
      cycle(1, 1, 3'd3);
      cycle(1, 0, 3'd0);
      cycle(0, 0, 3'd0);
      chk("abort_q", 32'(q), 32'h0);
      cycle(0, 1, 3'd1);
      repeat (P + G + 2) cycle(1, 0, 3'd0);

      // Hold a request while busy
      cycle(1, 1, 3'd2);
      repeat (2 * (P + G) + 2) cycle(1, 1, 3'd7);
      repeat (P + G + 2) cycle(1, 0, 3'd0);

      // Asynchronous reset mid-pulse
      cycle(1, 1, 3'd4);
      cycle(1, 1, 3'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_q", 32'(q), 32'h0);
      chk("async_busy", 32'(busy), 32'h0);
      chk("async_done", 32'(done), 32'h0);
      m_clear();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (P + G + 2) cycle(1, 0, 3'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 10) != 0, $urandom % 2, 3'($urandom % 8));
      end
      repeat (P + G + 2) cycle(1, 0, 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
